// File: rtl/edge_fifo_reader_pkg.sv
// Shared types and constants for the edge FIFO reader: FSM state encoding and
// output buffer sizing.
package edge_fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BUF_DEPTH = 2;
  // Occupancy counts 0..BUF_DEPTH inclusive.
  localparam int OCC_BITS  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/edge_fifo_reader_skid2.sv
// stream_skid2: two-entry in-order valid/ready buffer. The head entry drives
// the output and only moves on an accept, so a stalled word stays stable.
import edge_fifo_reader_pkg::*;

module stream_skid2 #(
  parameter int WIDTH = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  input  logic                out_ready,
  output logic [OCC_BITS-1:0] occupancy
);

  logic [WIDTH-1:0]    head_q, head_d;
  logic [WIDTH-1:0]    tail_q, tail_d;
  logic [OCC_BITS-1:0] count_q, count_d;
  logic                pop;
  logic                push;

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign occupancy = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop     = out_valid && out_ready;
    // The producer never pushes into a full buffer without a same-cycle pop.
    push    = in_valid && ((count_q < OCC_BITS'(BUF_DEPTH)) || pop);
    unique case ({push, pop})
      2'b10: begin
        if (count_q == '0) begin
          head_d = in_data;
        end else begin
          tail_d = in_data;
        end
        count_d = count_q + OCC_BITS'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - OCC_BITS'(1);
      end
      2'b11: begin
        if (count_q == OCC_BITS'(1)) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/edge_fifo_reader.sv
// Pops a requested number of packed edge records from a FIFO and streams them
// out over valid/ready, flagging the final word and pulsing done at the end.
import edge_fifo_reader_pkg::*;

module edge_fifo_reader #(
  parameter int WIDTH    = 96,
  parameter int LEN_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  output logic                busy,
  output logic                done,
  input  logic                fifo_empty,
  output logic                fifo_re,
  input  logic [WIDTH-1:0]    fifo_dout,
  output logic                m_valid,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_last,
  input  logic                m_ready
);

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] issued_q, issued_d;
  logic [LEN_BITS-1:0] accepted_q, accepted_d;
  logic                inflight_q, inflight_d;

  logic [OCC_BITS-1:0] occ;
  logic                accept;
  logic [2:0]          pending;
  logic                room;
  logic                drain_done;

  stream_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   (fifo_dout),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .occupancy (occ)
  );

  assign accept = m_valid && m_ready;
  assign busy   = (state_q != ST_IDLE);
  // accepted_q < len_q whenever m_valid is high, so the +1 cannot wrap.
  assign m_last = m_valid && ((accepted_q + LEN_BITS'(1)) == len_q);

  // Words already buffered or still in flight, net of this cycle's accept,
  // must leave space for one more pop.
  assign pending    = 3'(occ) + {2'b00, inflight_q};
  assign room       = pending < (3'd2 + {2'b00, accept});
  assign drain_done = !inflight_q
                   && (occ == OCC_BITS'(accept))
                   && ((accepted_q + LEN_BITS'(accept)) == len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    fifo_re    = 1'b0;
    done       = 1'b0;

    if (state_q == ST_RUN) begin
      fifo_re = !rst && !fifo_empty && (issued_q < len_q) && room;
    end
    if (fifo_re) begin
      issued_d = issued_q + LEN_BITS'(1);
    end
    if (accept) begin
      accepted_d = accepted_q + LEN_BITS'(1);
    end
    inflight_d = fifo_re;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = len;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_q == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
